// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO registers for the EX stage.
// Start/op handshake, fixed per-class latency (MULT_CYCLES / DIV_CYCLES), cancel from
// exception/interrupt flush, and a one-cycle done pulse when HI/LO take a computed result.
// Optional feature macro: MD_MADD_EN enables MADD/MADDU (ops 6/7) accumulating into {hi,lo}.
// When MD_MADD_EN is undefined, ops 6/7 are never accepted and no accumulate adder is built.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Operation encoding
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  // Counter only has to hold LAT-1 of the longer class
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic             accept;
  logic             is_long;
  logic             is_div;

  logic             mul_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  logic             div_signed;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign accept = start & ~cancel & ~busy_reg & (state_reg == IDLE);

  // Classify the requested op: long ops go through RUN, MTHI/MTLO complete on accept
  always_comb begin
    is_long = 1'b0;
    is_div  = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: is_long = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_long = 1'b1;
        is_div  = 1'b1;
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: is_long = 1'b1;
`endif
      default: ;
    endcase
  end

  // Full-width product of the latched operands; sign extension gives the signed product mod 2^(2W)
  always_comb begin
    mul_signed = (op_reg == OP_MULT) || (op_reg == OP_MADD);
    ext_a = mul_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    ext_b = mul_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
    product = ext_a * ext_b;
  end

  // Sign-magnitude divide: truncation toward zero, remainder takes the dividend's sign.
  // MIN_NEG / -1 naturally wraps back to MIN_NEG with remainder 0.
  always_comb begin
    div_signed = (op_reg == OP_DIV);
    neg_a   = div_signed & a_reg[WIDTH-1];
    neg_b   = div_signed & b_reg[WIDTH-1];
    mag_a   = neg_a ? (~a_reg + 1'b1) : a_reg;
    mag_b   = neg_b ? (~b_reg + 1'b1) : b_reg;
    divisor = (b_reg == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    q_mag   = mag_a / divisor;
    r_mag   = mag_a % divisor;
    quot    = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    rem     = neg_a ? (~r_mag + 1'b1) : r_mag;
  end

  // Result selection for the completion edge; divide by zero yields zero in both halves
  always_comb begin
    res_hi = hi_reg;
    res_lo = lo_reg;
    case (op_reg)
      OP_MULT, OP_MULTU: {res_hi, res_lo} = product;
      OP_DIV, OP_DIVU: begin
        if (b_reg == '0) begin
          res_hi = '0;
          res_lo = '0;
        end else begin
          res_hi = rem;
          res_lo = quot;
        end
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: {res_hi, res_lo} = {hi_reg, lo_reg} + product;
`endif
      default: ;
    endcase
  end

  // IDLE/RUN control with registered busy/done; cancel always beats completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_long) begin
              op_reg    <= op;
              a_reg     <= a;
              b_reg     <= b;
              count_reg <= is_div ? DIV_LOAD : MULT_LOAD;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end else if (op == OP_MTHI) begin
              hi_reg <= a;
            end else if (op == OP_MTLO) begin
              lo_reg <= a;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            count_reg <= '0;
          end else if (count_reg == '0) begin
            hi_reg    <= res_hi;
            lo_reg    <= res_lo;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against a full-width
// arithmetic reference model of HI/LO. Follows MD_MADD_EN the same way as the design.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int MC    = 5;
  localparam int DC    = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cancel;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_hi;
  logic [31:0] model_lo;

  muldiv_unit #(.WIDTH(WIDTH), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Expected busy length per op; zero means the op never enters RUN
  function automatic int exp_lat(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return MC;
      3'd2, 3'd3: return DC;
`ifdef MD_MADD_EN
      3'd6, 3'd7: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  // Reference model: 64-bit integer arithmetic on the architectural HI/LO pair
  function automatic void model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    logic [63:0] p, acc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); model_hi = p[63:32]; model_lo = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; model_hi = p[63:32]; model_lo = p[31:0]; end
      3'd2: begin
        if (y == 0) begin model_hi = 0; model_lo = 0; end
        else begin sq = sx / sy; sr = sx % sy; model_lo = sq[31:0]; model_hi = sr[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin model_hi = 0; model_lo = 0; end
        else begin model_lo = x / y; model_hi = x % y; end
      end
      3'd4: model_hi = x;
      3'd5: model_lo = x;
`ifdef MD_MADD_EN
      3'd6, 3'd7: begin
        p = (o == 3'd6) ? 64'(sx * sy) : {32'd0, x} * {32'd0, y};
        acc = {model_hi, model_lo} + p;
        model_hi = acc[63:32];
        model_lo = acc[31:0];
      end
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h7FFFFFFF;
    case ($urandom_range(0, 3))
      0: return specials[$urandom_range(0, 4)];
      1: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drive one request, scramble operands after the accept edge, wait out busy (bounded)
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cycles, output logic done_early, output logic done_end);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cycles = 0; done_early = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      if (done !== 1'b0) done_early = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    done_end = done;
    $display("op=%0d a=%h b=%h cycles=%0d -> hi=%h lo=%h done=%b", o, x, y, cycles, hi, lo, done_end);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b0;
    model_hi = 0; model_lo = 0;
  endtask

  task automatic test_vectors();
    logic [2:0]  v_op [4];
    logic [31:0] v_a [4], v_b [4], v_hi [4], v_lo [4];
    int cyc, lat;
    logic de, dn;
    v_op[0] = 3'd0; v_a[0] = 32'hFFFFFFFE; v_b[0] = 32'd3;        v_hi[0] = 32'hFFFFFFFF; v_lo[0] = 32'hFFFFFFFA;
    v_op[1] = 3'd2; v_a[1] = 32'hFFFFFFF9; v_b[1] = 32'd2;        v_hi[1] = 32'hFFFFFFFF; v_lo[1] = 32'hFFFFFFFD;
    v_op[2] = 3'd3; v_a[2] = 32'h80000000; v_b[2] = 32'd0;        v_hi[2] = 32'h0;        v_lo[2] = 32'h0;
    v_op[3] = 3'd2; v_a[3] = 32'h80000000; v_b[3] = 32'hFFFFFFFF; v_hi[3] = 32'h0;        v_lo[3] = 32'h80000000;
    for (int i = 0; i < 4; i++) begin
      lat = (v_op[i] == 3'd0) ? MC : DC;
      run_op(v_op[i], v_a[i], v_b[i], cyc, de, dn);
      model_apply(v_op[i], v_a[i], v_b[i]);
      n_checks++; if (cyc !== lat) begin n_fail++; $display("FAIL vec%0d_busy_cycles: got %0d expected %0d", i, cyc, lat); end
      n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL vec%0d_done_early: got %b expected 0", i, de); end
      n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL vec%0d_done: got %b expected 1", i, dn); end
      n_checks++; if (hi !== v_hi[i]) begin n_fail++; $display("FAIL vec%0d_hi: got %h expected %h", i, hi, v_hi[i]); end
      n_checks++; if (lo !== v_lo[i]) begin n_fail++; $display("FAIL vec%0d_lo: got %h expected %h", i, lo, v_lo[i]); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL vec%0d_done_pulse_width: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_cancel();
    int cyc;
    logic de, dn, seen;
    run_op(3'd4, 32'h11, 32'h0, cyc, de, dn); model_apply(3'd4, 32'h11, 32'h0);
    run_op(3'd5, 32'h11, 32'h0, cyc, de, dn); model_apply(3'd5, 32'h11, 32'h0);
    op = 3'd1; a = 32'd7; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_before: got %b expected 1", busy); end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL cancel_hi: got %h expected 11", hi); end
    n_checks++; if (lo !== 32'h11) begin n_fail++; $display("FAIL cancel_lo: got %h expected 11", lo); end
    seen = done;
    repeat (6) begin @(posedge clk); #1; seen = seen | done; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: got %b expected 0", seen); end
    $display("cancel mid-MULTU -> hi=%h lo=%h", hi, lo);
    // cancel together with start drops the request, long or MTHI
    op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    op = 3'd4; a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_start_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== model_hi) begin n_fail++; $display("FAIL cancel_start_hi: got %h expected %h", hi, model_hi); end
    n_checks++; if (lo !== model_lo) begin n_fail++; $display("FAIL cancel_start_lo: got %h expected %h", lo, model_lo); end
    $display("cancel+start -> busy=%b hi=%h lo=%h", busy, hi, lo);
    // cancel on the finishing edge discards the result
    op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MC - 1) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cancel_last_busy: got %b expected 1", busy); end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_last_busy_after: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cancel_last_done: got %b expected 0", done); end
    n_checks++; if (lo !== model_lo) begin n_fail++; $display("FAIL cancel_last_lo: got %h expected %h", lo, model_lo); end
    $display("cancel on final edge -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mt_busy();
    int c;
    op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    c = 0;
    op = 3'd4; a = 32'hABCD;
    @(posedge clk); #1; c++;
    op = 3'd0; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; c++;
    start = 1'b0;
    while (busy === 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    model_apply(3'd3, 32'd100, 32'd7);
    n_checks++; if (c !== DC) begin n_fail++; $display("FAIL mt_busy_cycles: got %0d expected %0d", c, DC); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mt_busy_done: got %b expected 1", done); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL mt_busy_hi: got %h expected 2", hi); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL mt_busy_lo: got %h expected e", lo); end
    op = 3'd4; a = 32'hABCD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_apply(3'd4, 32'hABCD, 32'h0);
    n_checks++; if (hi !== 32'hABCD) begin n_fail++; $display("FAIL mthi_idle_hi: got %h expected abcd", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_idle_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_idle_done: got %b expected 0", done); end
    $display("MTHI while busy ignored, reissued -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_random(input int count, input string tag);
    logic [2:0] o;
    logic [31:0] x, y;
    int cyc, lat;
    logic de, dn;
    for (int i = 0; i < count; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick_operand();
      y = pick_operand();
      lat = exp_lat(o);
      run_op(o, x, y, cyc, de, dn);
      model_apply(o, x, y);
      n_checks++; if (cyc !== lat) begin n_fail++; $display("FAIL %s%0d_cycles op=%0d: got %0d expected %0d", tag, i, o, cyc, lat); end
      n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL %s%0d_done_early: got %b expected 0", tag, i, de); end
      n_checks++; if (dn !== (lat > 0)) begin n_fail++; $display("FAIL %s%0d_done op=%0d: got %b expected %b", tag, i, o, dn, lat > 0); end
      n_checks++; if (hi !== model_hi) begin n_fail++; $display("FAIL %s%0d_hi op=%0d a=%h b=%h: got %h expected %h", tag, i, o, x, y, hi, model_hi); end
      n_checks++; if (lo !== model_lo) begin n_fail++; $display("FAIL %s%0d_lo op=%0d a=%h b=%h: got %h expected %h", tag, i, o, x, y, lo, model_lo); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [3];
    int cyc;
    logic de, dn;
    ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd0;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], $urandom, 32'($urandom_range(1, 1000)), cyc, de, dn);
      n_checks++; if (cyc !== exp_lat(ops[i])) begin n_fail++; $display("FAIL b2b%0d_cycles: got %0d expected %0d", i, cyc, exp_lat(ops[i])); end
      n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_done: got %b expected 1", i, dn); end
    end
    // recompute results independently: latched operands are printed by run_op, so replay via model
    // is not possible after the fact; issue again with known operands for value checks
    run_op(3'd1, 32'd12345, 32'd678, cyc, de, dn); model_apply(3'd1, 32'd12345, 32'd678);
    run_op(3'd2, 32'hFFFFFF00, 32'd7, cyc, de, dn); model_apply(3'd2, 32'hFFFFFF00, 32'd7);
    n_checks++; if (lo !== model_lo) begin n_fail++; $display("FAIL b2b_div_lo: got %h expected %h", lo, model_lo); end
    n_checks++; if (hi !== model_hi) begin n_fail++; $display("FAIL b2b_div_hi: got %h expected %h", hi, model_hi); end
  endtask

  task automatic test_madd();
    int cyc;
    logic de, dn;
    run_op(3'd4, 32'h0, 32'h0, cyc, de, dn);        model_apply(3'd4, 32'h0, 32'h0);
    run_op(3'd5, 32'hFFFFFFFF, 32'h0, cyc, de, dn); model_apply(3'd5, 32'hFFFFFFFF, 32'h0);
`ifdef MD_MADD_EN
    run_op(3'd7, 32'd1, 32'd1, cyc, de, dn);
    n_checks++; if (cyc !== MC) begin n_fail++; $display("FAIL maddu_cycles: got %0d expected %0d", cyc, MC); end
    n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL maddu_done: got %b expected 1", dn); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL maddu_hi: got %h expected 1", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL maddu_lo: got %h expected 0", lo); end
    run_op(3'd6, 32'hFFFFFFFF, 32'd3, cyc, de, dn);
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL madd_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL madd_lo: got %h expected fffffffd", lo); end
    model_hi = 32'd0; model_lo = 32'hFFFFFFFD;
`else
    run_op(3'd7, 32'd1, 32'd1, cyc, de, dn);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL maddu_disabled_cycles: got %0d expected 0", cyc); end
    n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL maddu_disabled_done: got %b expected 0", dn); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL maddu_disabled_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL maddu_disabled_lo: got %h expected ffffffff", lo); end
`endif
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    logic de, dn, seen;
    run_op(3'd4, 32'h1234, 32'h0, cyc, de, dn);
    run_op(3'd5, 32'h5678, 32'h0, cyc, de, dn);
    op = 3'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = 0; model_lo = 0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
    seen = done;
    repeat (DC + 2) begin @(posedge clk); #1; seen = seen | done | busy; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet: got %b expected 0", seen); end
    $display("reset mid-DIV -> busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
    model_hi = 0; model_lo = 0;
    test_reset();
    test_vectors();
    test_cancel();
    test_mt_busy();
    test_back_to_back();
    test_random(40, "rnd");
    test_madd();
    test_random(20, "rnd2_");
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
